vending_machine_param: RTL and testbench
========================================

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL take parameters (name, default, meaning):
- ROWS, 4, selector rows (row button A..)
- COLS, 4, selector columns (column button 1..)
- MONEY_W, 16, width of all cent values
- STOCK_W, 4, per-slot stock counter width
- STOCK_INIT, 5, stock loaded into every slot at reset
- TIMEOUT, 1000, idle cycles before automatic refund
REQ-002 SHALL derive SEL_W = clog2(ROWS*COLS); slot index = row*COLS + col (A1=0, B4=7, D3=14).
REQ-003 SHALL have ports (name direction width meaning):
- clk in 1 sole clock, rising edge
- reset in 1 synchronous, active-high
- coin_valid in 1 coin event strobe
- coin_value in MONEY_W cents of this coin
- row_btn in ROWS one-hot row press, 1-cycle pulse
- col_btn in COLS one-hot column press, 1-cycle pulse
- cancel in 1 refund request
- price_we in 1 price table write
- price_slot in SEL_W slot written
- price_val in MONEY_W new price
- restock_valid in 1 stock add strobe
- restock_slot in SEL_W slot restocked
- restock_count in STOCK_W units added
- credit out MONEY_W accumulated money
- change out MONEY_W money returned, valid with change_valid
- change_valid out 1 one-cycle pulse
- price out MONEY_W price of latched slot
- selection out SEL_W latched slot index
- dispensing out 1 one-cycle vend pulse
- sold_out out 1 one-cycle pulse
- coin_reject out 1 one-cycle pulse
- sel_error out 1 one-cycle pulse, non-one-hot button

Function
REQ-004 SHALL implement states IDLE, ROW, CHECK, WAIT_PAY, VEND, REFUND.
REQ-005 SHALL add coin_value to credit the cycle after coin_valid. If the sum overflows MONEY_W, the coin SHALL be rejected (coin_reject pulse) and credit left unchanged.
REQ-006 SHALL latch a one-hot row_btn in IDLE or ROW and go to ROW; a later row press SHALL replace the latched row.
REQ-007 SHALL ignore col_btn outside ROW. A col_btn in ROW SHALL latch selection and go to CHECK next cycle.
REQ-008 Any non-one-hot, nonzero row_btn or col_btn SHALL be ignored and pulse sel_error.
REQ-009 In CHECK, exactly one cycle:
- stock==0 -> sold_out, IDLE, credit kept
- credit<price -> WAIT_PAY
- otherwise -> VEND
REQ-010 WAIT_PAY SHALL go to VEND on the first cycle credit>=price. A row press in WAIT_PAY SHALL go to ROW.
REQ-011 VEND SHALL last one cycle and SHALL:
- pulse dispensing and change_valid
- set change = credit - price
- clear credit
- decrement stock[selection]
- return to IDLE
REQ-012 REFUND SHALL last one cycle: change = credit, change_valid pulse, credit cleared, IDLE. It SHALL be entered on cancel from any state, or on timeout.
REQ-013 Timeout counter:
- counts every cycle when credit>0 or state!=IDLE
- clears on any coin, button, or cancel
- at TIMEOUT cycles -> REFUND
REQ-014 Simultaneous events:
- a coin in the same cycle as the completing col_btn SHALL be included in the CHECK comparison
- cancel SHALL override all other inputs
- price_we to the latched slot during CHECK/WAIT_PAY SHALL take effect next cycle
REQ-015 stock_next SHALL equal min(stock + restock_count - vend_dec, 2^STOCK_W-1), with restock and vend allowed in the same cycle.
REQ-016 price output SHALL track price_table[selection] combinationally from the latched selection.
REQ-017 change SHALL hold its value until the next change_valid.

Reset
REQ-018 On reset, all of the following SHALL be zero: credit, change, price, selection, and all pulses. State SHALL be IDLE and the timeout counter SHALL be cleared.
REQ-019 On reset, every stock counter SHALL be set to STOCK_INIT and the price table SHALL load DEFAULT_PRICES.
REQ-020 Reset mid-transaction SHALL discard credit with no refund; the system layer issues cancel before asserting reset.

Structure
REQ-021 Package vending_pkg SHALL hold:
- the state enum
- DEFAULT_PRICES (A1=100, A3=150, B4=175, D1=250, D3=200; other slots 100)
- the sel_w function
REQ-022 Sub-module vend_timeout_timer (parameter TIMEOUT; inputs clear, enable; output expired pulse) SHALL implement REQ-013.

Verification
REQ-023 Coins 25,25,25,25, then A, 2 -> dispensing; change=0; selection=1; price=100.
REQ-024 Coins 100,100, then A, 3 -> change=50 with change_valid; credit=0; stock[2]=STOCK_INIT-1.
REQ-025 Coin 100, then D, 1 -> price=250 in WAIT_PAY, no dispensing. Then coin 150 -> VEND, change=0.
REQ-026 Coin 100, then idle TIMEOUT cycles -> REFUND, change=100, credit=0. Repeat with cancel after 3 cycles -> change=100 on the cycle after.
REQ-027 Drain slot 0 to zero stock, then coins 100, A, 1 -> sold_out pulse, credit stays 100. Restock 2 -> the purchase succeeds.
REQ-028 Overflow and reset cases:
- credit 65500, coin 100 -> coin_reject, credit 65500
- reset mid-ROW -> all outputs 0, state IDLE

Source files
------------

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared FSM states, default price table and selector sizing
package vending_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_CHECK,
    S_WAIT_PAY,
    S_VEND,
    S_REFUND
  } state_t;

  // Indexed by row*4 + col for the default 4x4 selector (A1=0, A3=2, B4=7, D1=12, D3=14)
  localparam int DEFAULT_PRICES [16] = '{
    100, 100, 150, 100,
    100, 100, 100, 175,
    100, 100, 100, 100,
    250, 100, 200, 100
  };
  localparam int FALLBACK_PRICE = 100;

  function automatic int sel_w(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

  function automatic int default_price(input int slot);
    return (slot < 16) ? DEFAULT_PRICES[slot] : FALLBACK_PRICE;
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// rtl/vend_timeout_timer.sv - idle watchdog, pulses expired after TIMEOUT enabled cycles
module vend_timeout_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parameterised vending controller: credit, selection, stock, refunds
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int MONEY_W    = 16,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  parameter int TIMEOUT    = 1000,
  localparam int SEL_W     = sel_w(ROWS * COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  input  logic [ROWS-1:0]    row_btn,
  input  logic [COLS-1:0]    col_btn,
  input  logic               cancel,
  input  logic               price_we,
  input  logic [SEL_W-1:0]   price_slot,
  input  logic [MONEY_W-1:0] price_val,
  input  logic               restock_valid,
  input  logic [SEL_W-1:0]   restock_slot,
  input  logic [STOCK_W-1:0] restock_count,
  output logic [MONEY_W-1:0] credit,
  output logic [MONEY_W-1:0] change,
  output logic               change_valid,
  output logic [MONEY_W-1:0] price,
  output logic [SEL_W-1:0]   selection,
  output logic               dispensing,
  output logic               sold_out,
  output logic               coin_reject,
  output logic               sel_error
);

  localparam int NSLOTS = ROWS * COLS;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  state_t state, state_next;

  logic [MONEY_W-1:0] price_table [NSLOTS];
  logic [STOCK_W-1:0] stock       [NSLOTS];
  logic [STOCK_W-1:0] stock_next  [NSLOTS];
  logic [STOCK_W+1:0] stock_sum;

  logic [SEL_W-1:0]   row_base, row_dec, col_dec;
  logic               sel_valid;
  logic               row_ok, col_ok, row_bad, col_bad;
  logic [MONEY_W:0]   coin_sum;
  logic               coin_ovf, coin_ok;
  logic [MONEY_W-1:0] credit_sum;
  logic               expired, vend_go, refund_go, sold_go;

  assign row_ok  = $onehot(row_btn);
  assign col_ok  = $onehot(col_btn);
  assign row_bad = (row_btn != '0) && !row_ok;
  assign col_bad = (col_btn != '0) && !col_ok;

  always_comb begin
    row_dec = '0;
    col_dec = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_btn[i]) row_dec = SEL_W'(i * COLS);
    end
    for (int i = 0; i < COLS; i++) begin
      if (col_btn[i]) col_dec = SEL_W'(i);
    end
  end

  // credit_sum is the credit including any coin accepted this cycle; cancel discards the coin
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_value};
  assign coin_ovf   = coin_sum[MONEY_W];
  assign coin_ok    = coin_valid && !cancel && !coin_ovf;
  assign credit_sum = coin_ok ? coin_sum[MONEY_W-1:0] : credit;

  assign price = sel_valid ? price_table[selection] : '0;

  vend_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (coin_valid || (row_btn != '0) || (col_btn != '0) || cancel),
    .enable  ((credit != '0) || (state != S_IDLE)),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    sold_go    = 1'b0;
    if (cancel || expired) begin
      state_next = S_REFUND;
    end else begin
      case (state)
        S_IDLE:     if (row_ok) state_next = S_ROW;
        S_ROW: begin
          if (row_ok)      state_next = S_ROW;
          else if (col_ok) state_next = S_CHECK;
        end
        S_CHECK: begin
          if (stock[selection] == '0) begin
            state_next = S_IDLE;
            sold_go    = 1'b1;
          end else if (credit < price) begin
            state_next = S_WAIT_PAY;
          end else begin
            state_next = S_VEND;
          end
        end
        S_WAIT_PAY: begin
          if (credit >= price) state_next = S_VEND;
          else if (row_ok)     state_next = S_ROW;
        end
        default:    state_next = S_IDLE;
      endcase
    end
  end

  assign vend_go   = (state_next == S_VEND);
  assign refund_go = (state_next == S_REFUND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      credit       <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      dispensing   <= 1'b0;
      sold_out     <= 1'b0;
      coin_reject  <= 1'b0;
      sel_error    <= 1'b0;
      selection    <= '0;
      row_base     <= '0;
      sel_valid    <= 1'b0;
    end else begin
      state        <= state_next;
      change_valid <= vend_go || refund_go;
      dispensing   <= vend_go;
      sold_out     <= sold_go;
      coin_reject  <= coin_valid && !cancel && coin_ovf;
      sel_error    <= !cancel && (row_bad || col_bad);
      if (vend_go)        change <= credit_sum - price;
      else if (refund_go) change <= credit_sum;
      credit <= (vend_go || refund_go) ? '0 : credit_sum;
      if (row_ok && state_next == S_ROW) row_base <= row_dec;
      if (state == S_ROW && state_next == S_CHECK) begin
        selection <= row_base + col_dec;
        sel_valid <= 1'b1;
      end
    end
  end

  // Restock and vend may hit the same slot in one cycle; the result saturates at the counter max
  always_comb begin
    stock_sum = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      stock_sum = {2'b00, stock[i]}
                + ((restock_valid && restock_slot == SEL_W'(i)) ? {2'b00, restock_count} : '0)
                - {{(STOCK_W+1){1'b0}}, (vend_go && selection == SEL_W'(i))};
      stock_next[i] = (stock_sum > {2'b00, STOCK_MAX}) ? STOCK_MAX : stock_sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSLOTS; i++) begin
      if (reset) begin
        stock[i]       <= STOCK_W'(STOCK_INIT);
        price_table[i] <= MONEY_W'(default_price(i));
      end else begin
        stock[i] <= stock_next[i];
        if (price_we && price_slot == SEL_W'(i)) price_table[i] <= price_val;
      end
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// tb/tb_vending_machine_param.sv - vector table, corner sequences and randomized purchases vs a model
module tb_vending_machine_param;
  import vending_pkg::*;

  localparam int ROWS = 4, COLS = 4, MONEY_W = 16, STOCK_W = 4, STOCK_INIT = 5, TIMEOUT = 40;
  localparam int NS = ROWS * COLS;
  localparam int SEL_W = 4;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic reset, coin_valid, cancel, price_we, restock_valid;
  logic [MONEY_W-1:0] coin_value, price_val;
  logic [ROWS-1:0] row_btn;
  logic [COLS-1:0] col_btn;
  logic [SEL_W-1:0] price_slot, restock_slot;
  logic [STOCK_W-1:0] restock_count;
  logic [MONEY_W-1:0] credit, change, price;
  logic [SEL_W-1:0] selection;
  logic change_valid, dispensing, sold_out, coin_reject, sel_error;

  always #5 clk = ~clk;

  vending_machine_param #(
    .ROWS(ROWS), .COLS(COLS), .MONEY_W(MONEY_W), .STOCK_W(STOCK_W),
    .STOCK_INIT(STOCK_INIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .row_btn(row_btn), .col_btn(col_btn), .cancel(cancel), .price_we(price_we),
    .price_slot(price_slot), .price_val(price_val), .restock_valid(restock_valid),
    .restock_slot(restock_slot), .restock_count(restock_count), .credit(credit),
    .change(change), .change_valid(change_valid), .price(price), .selection(selection),
    .dispensing(dispensing), .sold_out(sold_out), .coin_reject(coin_reject),
    .sel_error(sel_error)
  );

  int n_cmp = 0, n_bad = 0;
  int m_stock [NS];
  int m_price [NS];
  int spec_price [NS] = '{100, 100, 150, 100, 100, 100, 100, 175,
                          100, 100, 100, 100, 250, 100, 200, 100};

  typedef struct {
    int c0, c1, c2, c3;
    int slot;
    int vend;
    int chg;
    int prc;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 0; coin_value = '0; row_btn = '0; col_btn = '0; cancel = 0;
    price_we = 0; price_slot = '0; price_val = '0;
    restock_valid = 0; restock_slot = '0; restock_count = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    cycle(); cycle();
    reset = 0;
    for (int i = 0; i < NS; i++) begin
      m_stock[i] = STOCK_INIT;
      m_price[i] = spec_price[i];
    end
  endtask

  task automatic coin(input int v);
    coin_valid = 1; coin_value = MONEY_W'(v);
    cycle();
    coin_valid = 0; coin_value = '0;
  endtask

  task automatic press_row(input int r);
    row_btn = ROWS'(1) << r;
    cycle();
    row_btn = '0;
  endtask

  task automatic press_col(input int c);
    col_btn = COLS'(1) << c;
    cycle();
    col_btn = '0;
  endtask

  task automatic choose(input int slot);
    press_row(slot / COLS);
    press_col(slot % COLS);
  endtask

  task automatic do_cancel();
    cancel = 1;
    cycle();
    cancel = 0;
  endtask

  task automatic restock(input int slot, input int cnt);
    restock_valid = 1; restock_slot = SEL_W'(slot); restock_count = STOCK_W'(cnt);
    cycle();
    restock_valid = 0;
    m_stock[slot] = (m_stock[slot] + cnt > SMAX) ? SMAX : m_stock[slot] + cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sum, slot, top, extra, exp_stock;
    int coin_set [5];
    coin_set = '{5, 10, 25, 50, 100};

    vecs[0] = '{25, 25, 25, 25, 1, 1, 0, 100};
    vecs[1] = '{100, 100, 0, 0, 2, 1, 50, 150};
    vecs[2] = '{200, 0, 0, 0, 7, 1, 25, 175};
    vecs[3] = '{250, 0, 0, 0, 14, 1, 50, 200};
    vecs[4] = '{300, 0, 0, 0, 12, 1, 50, 250};
    vecs[5] = '{100, 0, 0, 0, 12, 0, 100, 250};
    vecs[6] = '{5, 0, 0, 0, 9, 0, 5, 100};

    do_reset();
    check("reset_credit", 64'(credit), 64'(0));
    check("reset_change", 64'(change), 64'(0));
    check("reset_price", 64'(price), 64'(0));
    check("reset_selection", 64'(selection), 64'(0));
    check("reset_pulses", 64'({change_valid, dispensing, sold_out, coin_reject, sel_error}), 64'(0));
    check("reset_state", 64'(dut.state), 64'(S_IDLE));

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].c0 != 0) coin(vecs[i].c0);
      if (vecs[i].c1 != 0) coin(vecs[i].c1);
      if (vecs[i].c2 != 0) coin(vecs[i].c2);
      if (vecs[i].c3 != 0) coin(vecs[i].c3);
      choose(vecs[i].slot);
      cycle();
      check("vec_dispensing", 64'(dispensing), 64'(vecs[i].vend));
      check("vec_selection", 64'(selection), 64'(vecs[i].slot));
      check("vec_price", 64'(price), 64'(vecs[i].prc));
      if (vecs[i].vend != 0) m_stock[vecs[i].slot]--;
      else do_cancel();
      check("vec_change_valid", 64'(change_valid), 64'(1));
      check("vec_change", 64'(change), 64'(vecs[i].chg));
      check("vec_credit", 64'(credit), 64'(0));
      cycle();
      check("vec_change_hold", 64'(change), 64'(vecs[i].chg));
    end
    check("stock_after_a3", 64'(dut.stock[2]), 64'(STOCK_INIT - 1));

    // pay in two steps: WAIT_PAY then VEND on top-up
    coin(100); choose(12); cycle();
    check("waitpay_price", 64'(price), 64'(250));
    check("waitpay_nodisp", 64'(dispensing), 64'(0));
    cycle();
    check("waitpay_still", 64'(dispensing), 64'(0));
    coin(150); cycle();
    check("topup_disp", 64'(dispensing), 64'(1));
    check("topup_change", 64'(change), 64'(0));
    m_stock[12]--; cycle();

    // idle timeout refund
    coin(100);
    n = 0;
    while (!change_valid && n < 3 * TIMEOUT) begin cycle(); n++; end
    check("timeout_refund", 64'(change_valid), 64'(1));
    check("timeout_cycles", 64'(n), 64'(TIMEOUT));
    check("timeout_change", 64'(change), 64'(100));
    check("timeout_credit", 64'(credit), 64'(0));
    cycle();

    coin(100); cycle(); cycle(); cycle();
    check("cancel_pre", 64'(change_valid), 64'(0));
    do_cancel();
    check("cancel_valid", 64'(change_valid), 64'(1));
    check("cancel_change", 64'(change), 64'(100));
    cycle();

    // credit overflow boundary
    coin(65500);
    check("ovf_credit0", 64'(credit), 64'(65500));
    coin(100);
    check("ovf_reject", 64'(coin_reject), 64'(1));
    check("ovf_credit1", 64'(credit), 64'(65500));
    coin(35);
    check("ovf_edge_reject", 64'(coin_reject), 64'(0));
    check("ovf_edge_credit", 64'(credit), 64'(65535));
    do_cancel();
    check("ovf_refund", 64'(change), 64'(65535));
    cycle();

    // malformed buttons and stray column press
    row_btn = 4'b0101; cycle(); row_btn = '0;
    check("selerr_pulse", 64'(sel_error), 64'(1));
    check("selerr_state", 64'(dut.state), 64'(S_IDLE));
    press_col(1);
    check("selerr_clear", 64'(sel_error), 64'(0));
    check("col_in_idle", 64'(dut.state), 64'(S_IDLE));

    // later row press replaces the latched row
    press_row(0); press_row(1); press_col(3);
    check("row_replace_sel", 64'(selection), 64'(7));
    do_cancel(); cycle();

    // price rewrite while waiting for payment
    price_we = 1; price_slot = 4'd5; price_val = 16'd120; cycle(); price_we = 0;
    m_price[5] = 120;
    coin(100); choose(5); cycle();
    check("pw_wait_price", 64'(price), 64'(120));
    check("pw_wait_nodisp", 64'(dispensing), 64'(0));
    price_we = 1; price_slot = 4'd5; price_val = 16'd80; cycle(); price_we = 0;
    m_price[5] = 80;
    check("pw_new_price", 64'(price), 64'(80));
    cycle();
    check("pw_disp", 64'(dispensing), 64'(1));
    check("pw_change", 64'(change), 64'(20));
    m_stock[5]--; cycle();

    // coin arriving with the completing column press counts
    coin(100); press_row(0);
    coin_valid = 1; coin_value = 16'd50; col_btn = 4'b0100; cycle();
    coin_valid = 0; col_btn = '0; cycle();
    check("coin_col_disp", 64'(dispensing), 64'(1));
    check("coin_col_change", 64'(change), 64'(0));
    m_stock[2]--; cycle();

    // restock landing on the vend edge for the same slot
    coin(100); choose(4);
    exp_stock = m_stock[4] + 2 - 1;
    restock(4, 2);
    check("rs_vend_disp", 64'(dispensing), 64'(1));
    m_stock[4] = exp_stock;
    check("rs_vend_stock", 64'(dut.stock[4]), 64'(exp_stock));
    cycle();
    restock(3, 15);
    check("rs_saturate", 64'(dut.stock[3]), 64'(m_stock[3]));

    // drain A1, then sold out, then restock and buy
    n = 0;
    while (m_stock[0] > 0 && n < 20) begin
      coin(100); choose(0); cycle();
      check("drain_disp", 64'(dispensing), 64'(1));
      m_stock[0]--; n++; cycle();
    end
    coin(100); choose(0); cycle();
    check("soldout_pulse", 64'(sold_out), 64'(1));
    check("soldout_nodisp", 64'(dispensing), 64'(0));
    check("soldout_credit", 64'(credit), 64'(100));
    cycle();
    check("soldout_once", 64'(sold_out), 64'(0));
    restock(0, 2);
    choose(0); cycle();
    check("restock_buy", 64'(dispensing), 64'(1));
    check("restock_change", 64'(change), 64'(0));
    m_stock[0]--; cycle();

    // randomized purchases against the transaction model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) restock($urandom_range(0, 3), $urandom_range(0, 3));
      slot = $urandom_range(0, 3);
      sum = 0;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        top = coin_set[$urandom_range(0, 4)];
        sum += top;
        coin(top);
      end
      choose(slot); cycle();
      if (m_stock[slot] == 0) begin
        check("rnd_soldout", 64'(sold_out), 64'(1));
        check("rnd_sold_credit", 64'(credit), 64'(sum));
        cycle(); do_cancel();
        check("rnd_sold_refund", 64'(change), 64'(sum));
      end else if (sum >= m_price[slot]) begin
        check("rnd_disp", 64'(dispensing), 64'(1));
        check("rnd_change", 64'(change), 64'(sum - m_price[slot]));
        m_stock[slot]--;
      end else begin
        check("rnd_wait", 64'(dispensing), 64'(0));
        extra = 5 * $urandom_range(0, 2);
        coin(m_price[slot] - sum + extra); cycle();
        check("rnd_topup_disp", 64'(dispensing), 64'(1));
        check("rnd_topup_change", 64'(change), 64'(extra));
        m_stock[slot]--;
      end
      cycle();
    end

    // reset in the middle of a selection
    coin(100); press_row(2);
    reset = 1; cycle(); reset = 0;
    check("midrst_credit", 64'(credit), 64'(0));
    check("midrst_change", 64'(change), 64'(0));
    check("midrst_price", 64'(price), 64'(0));
    check("midrst_selection", 64'(selection), 64'(0));
    check("midrst_pulses", 64'({change_valid, dispensing, sold_out, coin_reject, sel_error}), 64'(0));
    check("midrst_state", 64'(dut.state), 64'(S_IDLE));
    check("midrst_stock", 64'(dut.stock[0]), 64'(STOCK_INIT));
    check("midrst_ptable", 64'(dut.price_table[5]), 64'(spec_price[5]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
